// File: rtl/dlx_pkg.sv
// Shared constants and entry type for the DLX fetch stage.
package dlx_pkg;

  localparam int unsigned INST_W       = 32;
  localparam logic [31:0] PC_STEP      = 32'd4;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [INST_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/dlx_fetch_queue_if.sv
// Fetch-stage bus: ROM address/data, pipeline redirect and decode handshake.
interface dlx_fetch_queue_if #(
  parameter int unsigned DEPTH = 4
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [dlx_pkg::INST_W-1:0] rom_addr;
  logic [dlx_pkg::INST_W-1:0] rom_data;
  logic                       redirect_en;
  logic [dlx_pkg::INST_W-1:0] redirect_pc;
  logic                       stall;
  logic                       inst_valid;
  logic [dlx_pkg::INST_W-1:0] inst;
  logic [dlx_pkg::INST_W-1:0] inst_pc;
  logic [CNT_W-1:0]           count;

  modport master (
    output rom_addr, inst_valid, inst, inst_pc, count,
    input  rom_data, redirect_en, redirect_pc, stall
  );

  modport slave (
    input  rom_addr, inst_valid, inst, inst_pc, count,
    output rom_data, redirect_en, redirect_pc, stall
  );

endinterface

// File: rtl/dlx_sync_fifo.sv
// Synchronous FIFO with flush; head is combinational from the read pointer.
module dlx_sync_fifo #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [Width-1:0] wdata_i,
  output logic [Width-1:0] head_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      // Dropping everything queued: the read side jumps to the write side.
      rd_ptr_q <= wr_ptr_q;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i && push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i) begin
      assert (!(push_i && !pop_i && (cnt_q == CntW'(Depth))));
      assert (!(pop_i && (cnt_q == '0)));
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/dlx_fetch_queue.sv
// DLX fetch stage: owns the fetch PC, prefetches ROM words into a tagged FIFO, flushes on redirect.
module dlx_fetch_queue
  import dlx_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic              clock,
  input  logic              reset,
  dlx_fetch_queue_if.master bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [INST_W-1:0] fpc_q, fpc_d;
  logic [INST_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              inflight_q, inflight_d;
  logic              issue, push, pop, flush, head_valid;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    credit_used;
  fetch_entry_t      head, wentry;

  always_comb begin
    // Credit counts the word already in flight; a same-cycle dequeue is ignored.
    credit_used   = {1'b0, count} + {{CNT_W{1'b0}}, inflight_q};
    issue         = !bus.redirect_en && (credit_used < (CNT_W + 1)'(DEPTH));
    flush         = bus.redirect_en;
    push          = inflight_q && !bus.redirect_en;
    head_valid    = (count != '0);
    pop           = head_valid && !bus.stall && !bus.redirect_en;
    wentry.pc     = inflight_pc_q;
    wentry.inst   = bus.rom_data;
    fpc_d         = fpc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (bus.redirect_en) begin
      fpc_d = bus.redirect_pc;
    end else if (issue) begin
      fpc_d         = fpc_q + PC_STEP;
      inflight_d    = 1'b1;
      inflight_pc_d = fpc_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fpc_q         <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fpc_q         <= fpc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  dlx_sync_fifo #(
    .Width ($bits(fetch_entry_t)),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (wentry),
    .head_o  (head),
    .count_o (count)
  );

  assign bus.rom_addr   = fpc_q;
  assign bus.inst_valid = head_valid;
  assign bus.inst       = head_valid ? head.inst : NOP_INST;
  assign bus.inst_pc    = head_valid ? head.pc : '0;
  assign bus.count      = count;

endmodule

// File: tb/tb_dlx_fetch_queue.sv
// Directed bench for dlx_fetch_queue with a registered ROM model (data = addr ^ 32'hA5A5_0000).
module tb_dlx_fetch_queue;

  localparam logic [31:0] ROM_XOR = 32'hA5A5_0000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   got;
  logic [31:0] exp_pc;

  dlx_fetch_queue_if #(.DEPTH(4)) bus ();

  dlx_fetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000),
    .NOP_INST (32'h0000_0000)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // ROM: word for the address presented this cycle appears next cycle.
  always_ff @(posedge clock) bus.rom_data <= bus.rom_addr ^ ROM_XOR;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.stall       = 1'b0;
    bus.redirect_en = 1'b0;
    bus.redirect_pc = 32'h0;

    // Reset state
    step(); step();
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_valid", 32'(bus.inst_valid), 0);
    chk("rst_inst", bus.inst, 0);
    chk("rst_inst_pc", bus.inst_pc, 0);
    chk("rst_rom_addr", bus.rom_addr, 0);

    // Free run: cycle 0 issues PC 0, valid in cycle 2
    reset = 1'b0;
    step();
    chk("free_c1_valid", 32'(bus.inst_valid), 0);
    chk("free_c1_rom_addr", bus.rom_addr, 32'h4);
    step();
    for (int i = 0; i < 6; i++) begin
      chk("free_valid", 32'(bus.inst_valid), 1);
      chk("free_pc", bus.inst_pc, 32'(4 * i));
      chk("free_inst", bus.inst, 32'(4 * i) ^ ROM_XOR);
      chk("free_count_le2", 32'(bus.count <= 2), 1);
      step();
    end

    // Stall from the cycle PC 0 is valid: fill to DEPTH, then drain
    reset = 1'b1; step(); reset = 1'b0;
    step(); step();
    chk("stall_c2_pc0", bus.inst_pc, 0);
    bus.stall = 1'b1;
    step(); step(); step();
    chk("stall_full_count", 32'(bus.count), 4);
    chk("stall_rom_addr", bus.rom_addr, 32'd16);
    chk("stall_head", bus.inst_pc, 0);
    step();
    chk("stall_hold_count", 32'(bus.count), 4);
    chk("stall_hold_rom_addr", bus.rom_addr, 32'd16);
    chk("stall_hold_head", bus.inst, ROM_XOR);
    bus.stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 1) chk("drain_resume_addr", bus.rom_addr, 32'd16);
      chk("drain_valid", 32'(bus.inst_valid), 1);
      chk("drain_pc", bus.inst_pc, 32'(4 * i));
      chk("drain_inst", bus.inst, 32'(4 * i) ^ ROM_XOR);
      step();
    end

    // Redirect with 3 queued and 1 in flight
    reset = 1'b1; step(); reset = 1'b0;
    step(); step();
    bus.stall = 1'b1;
    step(); step();
    chk("redir_pre_count", 32'(bus.count), 3);
    bus.stall       = 1'b0;
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 32'h100;
    step();
    bus.redirect_en = 1'b0;
    chk("redir_count", 32'(bus.count), 0);
    chk("redir_valid", 32'(bus.inst_valid), 0);
    chk("redir_rom_addr", bus.rom_addr, 32'h100);
    step();
    chk("redir_no_stale", 32'(bus.inst_valid), 0);
    step();
    chk("redir_tgt_valid", 32'(bus.inst_valid), 1);
    chk("redir_tgt_pc", bus.inst_pc, 32'h100);
    chk("redir_tgt_inst", bus.inst, 32'h100 ^ ROM_XOR);

    // Fill under stall, then redirect while stalled and full
    bus.stall = 1'b1;
    step(); step(); step();
    chk("redir2_full", 32'(bus.count), 4);
    chk("redir2_rom_addr", bus.rom_addr, 32'h110);
    chk("redir2_head", bus.inst_pc, 32'h100);
    bus.redirect_en = 1'b1;
    bus.redirect_pc = 32'h200;
    step();
    bus.redirect_en = 1'b0;
    chk("redir2_count", 32'(bus.count), 0);
    chk("redir2_valid", 32'(bus.inst_valid), 0);
    chk("redir2_inst_nop", bus.inst, 0);
    chk("redir2_fpc", bus.rom_addr, 32'h200);
    bus.stall = 1'b0;
    step();
    chk("redir2_no_stale", 32'(bus.inst_valid), 0);
    step();
    chk("redir2_tgt_pc", bus.inst_pc, 32'h200);
    chk("redir2_tgt_valid", 32'(bus.inst_valid), 1);

    // Mid-stream reset with 2 entries queued
    bus.stall = 1'b1;
    step();
    chk("mid_pre_count", 32'(bus.count), 2);
    reset = 1'b1;
    step();
    chk("mid_rst_count", 32'(bus.count), 0);
    chk("mid_rst_valid", 32'(bus.inst_valid), 0);
    chk("mid_rst_inst", bus.inst, 0);
    chk("mid_rst_inst_pc", bus.inst_pc, 0);
    chk("mid_rst_rom_addr", bus.rom_addr, 0);
    reset = 1'b0;
    step(); step();
    chk("mid_restart_valid", 32'(bus.inst_valid), 1);
    chk("mid_restart_pc", bus.inst_pc, 0);

    // Random stall scoreboard over 100 instructions
    reset = 1'b1; step(); reset = 1'b0;
    got    = 0;
    exp_pc = 32'h0;
    for (int cyc = 0; cyc < 2000 && got < 100; cyc++) begin
      bus.stall = 1'($urandom_range(0, 1));
      chk("rand_count_le_depth", 32'(bus.count <= 4), 1);
      if (bus.inst_valid) begin
        chk("rand_pc", bus.inst_pc, exp_pc);
        chk("rand_inst", bus.inst, exp_pc ^ ROM_XOR);
        if (!bus.stall) begin
          got++;
          exp_pc += 32'd4;
        end
      end
      step();
    end
    chk("rand_received", 32'(got), 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
